// File: rtl/bus_slave_if_if.sv
// Bus-side signal bundle for bus_slave_if.
// Active-low chip select, address strobe and ready, plus the word address
// and both data directions. The master drives the request half and the
// slave drives rd_data/rdy_.
interface bus_slave_if_if;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;

    modport master (
        output cs_, as_, rw, addr, wr_data,
        input  rd_data, rdy_
    );

    modport slave (
        input  cs_, as_, rw, addr, wr_data,
        output rd_data, rdy_
    );
endinterface

// File: rtl/bus_slave_if.sv
// bus_slave_if: bridges a strobe/ready style system bus onto a simple
// level-request / ack device port.
// A bus access (cs_=0, as_=0) is latched and held on the device port until
// the device acks. The result is then returned with a single rdy_ pulse.
// rd_data is forced to zero whenever rdy_ is high, so several slaves can
// share an OR-mux.
// Optional feature: define BUS_SLAVE_TIMEOUT_EN to add a device-ack timeout.
// The timeout completes the access with 32'hDEAD_BEEF on reads and sets a
// sticky err flag.
module bus_slave_if #(
    parameter int LOCAL_ADDR_W = 8,   // 1..29 low word-address bits forwarded
    parameter int TIMEOUT_CYC  = 255  // 1..255 REQ cycles tolerated without ack
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_slave_if_if.slave           bus,
    output logic                    dev_req,
    output logic [LOCAL_ADDR_W-1:0] dev_addr,
    output logic                    dev_rw,
    output logic [31:0]             dev_wr_data,
    input  logic [31:0]             dev_rd_data,
    input  logic                    dev_ack,
    output logic                    err
);

    localparam logic        RW_READ      = 1'b1;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    // Count value seen in the last REQ cycle before the timeout fires.
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [LOCAL_ADDR_W-1:0] dev_addr_q, dev_addr_d;
    logic                    dev_rw_q, dev_rw_d;
    logic [31:0]             dev_wr_data_q, dev_wr_data_d;
    logic [31:0]             rd_buf_q, rd_buf_d;
`ifdef BUS_SLAVE_TIMEOUT_EN
    logic [7:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
`endif

    // The upper address bits are decoded by the bus fabric, not by this block.
    // TIMEOUT_LAST is only consumed when the timeout is built in.
    logic unused_cfg;
    assign unused_cfg = ^{bus.addr[29:LOCAL_ADDR_W], TIMEOUT_LAST};

    // State register and latched access fields.
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            dev_addr_q    <= '0;
            dev_rw_q      <= RW_READ;
            dev_wr_data_q <= '0;
            rd_buf_q      <= '0;
`ifdef BUS_SLAVE_TIMEOUT_EN
            cnt_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            dev_addr_q    <= dev_addr_d;
            dev_rw_q      <= dev_rw_d;
            dev_wr_data_q <= dev_wr_data_d;
            rd_buf_q      <= rd_buf_d;
`ifdef BUS_SLAVE_TIMEOUT_EN
            cnt_q         <= cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    // Next-state logic: capture in IDLE, wait for ack (or timeout) in REQ,
    // then spend a single cycle in RESP.
    // NOTE: every _d signal gets its hold value before the case statement.
    // That way no path through the block leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        dev_addr_d    = dev_addr_q;
        dev_rw_d      = dev_rw_q;
        dev_wr_data_d = dev_wr_data_q;
        rd_buf_d      = rd_buf_q;
`ifdef BUS_SLAVE_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // An address strobe without chip select belongs to another slave.
                if (!bus.cs_ && !bus.as_) begin
                    dev_addr_d    = bus.addr[LOCAL_ADDR_W-1:0];
                    dev_rw_d      = bus.rw;
                    dev_wr_data_d = bus.wr_data;
`ifdef BUS_SLAVE_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                    state_d       = REQ;
                end
            end
            REQ: begin
                // An ack takes priority over a timeout landing in the same cycle.
                if (dev_ack) begin
                    if (dev_rw_q == RW_READ) begin
                        rd_buf_d = dev_rd_data;
                    end
                    state_d = RESP;
                end
`ifdef BUS_SLAVE_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_d = 1'b1;
                    if (dev_rw_q == RW_READ) begin
                        rd_buf_d = TIMEOUT_DATA;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers. dev_req is high exactly while
    // in REQ, and rdy_/rd_data are live only in RESP.
    assign dev_req     = (state_q == REQ);
    assign dev_addr    = dev_addr_q;
    assign dev_rw      = dev_rw_q;
    assign dev_wr_data = dev_wr_data_q;
    assign bus.rdy_    = (state_q != RESP);
    assign bus.rd_data = (state_q == RESP && dev_rw_q == RW_READ) ? rd_buf_q : '0;
`ifdef BUS_SLAVE_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule
